fpga_exit_reporter: RTL and testbench



---
 rtl/fpga_exit_reporter_pkg.sv | 60 ++++++
 rtl/fpga_exit_reporter_uart_tx_byte.sv | 85 ++++++++
 rtl/fpga_exit_reporter.sv | 130 +++++++++++++
 tb/tb_fpga_exit_reporter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_exit_reporter_pkg.sv
// Shared types, constants and helpers for the exit reporter.
// The report line is "EXIT 0x" + 8 uppercase hex digits + CR + LF.
package fpga_exit_reporter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

  localparam int unsigned MSG_LEN    = 17;
  localparam int unsigned PREFIX_LEN = 7;

  localparam logic [7:0] ChE     = 8'h45;  // 'E'
  localparam logic [7:0] ChX     = 8'h58;  // 'X'
  localparam logic [7:0] ChI     = 8'h49;  // 'I'
  localparam logic [7:0] ChT     = 8'h54;  // 'T'
  localparam logic [7:0] ChSpace = 8'h20;  // ' '
  localparam logic [7:0] ChZero  = 8'h30;  // '0'
  localparam logic [7:0] ChLowX  = 8'h78;  // 'x'
  localparam logic [7:0] ChCr    = 8'h0D;
  localparam logic [7:0] ChLf    = 8'h0A;

  function automatic logic [7:0] hex_ascii(logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) res = 8'h30 + {4'h0, nib};
    else             res = 8'h37 + {4'h0, nib};
    return res;
  endfunction

  function automatic logic [7:0] prefix_byte(logic [2:0] idx);
    logic [7:0] res;
    case (idx)
      3'd0:    res = ChE;
      3'd1:    res = ChX;
      3'd2:    res = ChI;
      3'd3:    res = ChT;
      3'd4:    res = ChSpace;
      3'd5:    res = ChZero;
      default: res = ChLowX;
    endcase
    return res;
  endfunction

  // Byte idx (0..MSG_LEN-1) of the report line for a given exit value.
  function automatic logic [7:0] msg_char(logic [4:0] idx, logic [31:0] value);
    logic [7:0]  res;
    logic [4:0]  hex_pos;
    logic [31:0] shifted;
    hex_pos = idx - 5'(PREFIX_LEN);
    // Move the wanted nibble to the top so the MSB nibble goes first.
    shifted = value << {hex_pos[2:0], 2'b00};
    if (idx < 5'(PREFIX_LEN))           res = prefix_byte(idx[2:0]);
    else if (idx < 5'(PREFIX_LEN + 8))  res = hex_ascii(shifted[31:28]);
    else if (idx == 5'(PREFIX_LEN + 8)) res = ChCr;
    else                                res = ChLf;
    return res;
  endfunction

endpackage

// File: rtl/fpga_exit_reporter_uart_tx_byte.sv
// 8N1 UART byte serializer with back-to-back capability.
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   byte_i        byte to send, taken when valid_i && ready_o
//   valid_i       request to send byte_i
//   ready_o       idle, or finishing the stop bit this cycle
//   tx_o          registered serial line, idle high
//   done_o        1-cycle pulse in the last cycle of the stop bit
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       done_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] StopIdx = 4'd9;

  logic            active_q, active_d;
  logic            tx_q, tx_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      bit_q, bit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bit_end, load;

  assign bit_end = active_q && (cnt_q == CntMax);
  assign done_o  = bit_end && (bit_q == StopIdx);
  // Accepting during the final stop cycle keeps frames back-to-back.
  assign ready_o = !active_q || done_o;
  assign load    = valid_i && ready_o;
  assign tx_o    = tx_q;

  always_comb begin
    active_d = active_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    if (load) begin
      active_d = 1'b1;
      tx_d     = 1'b0;
      shift_d  = byte_i;
      bit_d    = 4'd0;
      cnt_d    = '0;
    end else if (active_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (bit_q == StopIdx) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          // Ones shift in behind the data so the stop bit falls out naturally.
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[7:1]};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      shift_q  <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fpga_exit_reporter.sv
// Latches the SoC exit value on a rising exit_valid_i, drives pass/fail LEDs
// and sends "EXIT 0xHHHHHHHH\r\n" over a UART TX pin.
// Build option FPGA_EXIT_REPORTER_UART_EN: when undefined, no serializer or
// message ROM is built, tx_o is tied high and SEND lasts one cycle.
// Ports:
//   clk_i, rst_i   clock and asynchronous active-high reset
//   exit_valid_i   SoC exit-valid level
//   exit_value_i   SoC exit value, sampled on capture
//   tx_o           UART 8N1 output, idle high
//   busy_o         report in progress (state SEND)
//   done_o         report for the last capture sent (state DONE)
//   pass_led_o     last captured value == 0
//   fail_led_o     last captured value != 0
//   value_o        last captured value
module fpga_exit_reporter
  import fpga_exit_reporter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_led_o,
  output logic        fail_led_o,
  output logic [31:0] value_o
);

  state_e      state_q, state_d;
  logic        valid_q;
  logic [31:0] value_q;
  logic        pass_q, fail_q;
  logic        capture;

  // Edges seen while sending are dropped, but valid_q still tracks the level.
  assign capture = exit_valid_i && !valid_q && ((state_q == StIdle) || (state_q == StDone));

`ifdef FPGA_EXIT_REPORTER_UART_EN
  logic [4:0] idx_q;
  logic [4:0] send_idx;
  logic [7:0] msg_byte;
  logic       uart_valid, uart_ready, uart_done, uart_tx;

  // On the finishing cycle of a byte, present the following one so the
  // serializer can chain it without an idle bit.
  assign send_idx   = uart_done ? (idx_q + 5'd1) : idx_q;
  assign uart_valid = (state_q == StSend) && (send_idx < 5'(MSG_LEN));
  assign msg_byte   = msg_char(send_idx, value_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else if (capture) begin
      idx_q <= '0;
    end else if ((state_q == StSend) && uart_done) begin
      idx_q <= idx_q + 5'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .byte_i (msg_byte),
    .valid_i(uart_valid),
    .ready_o(uart_ready),
    .tx_o   (uart_tx),
    .done_o (uart_done)
  );

  assign tx_o = uart_tx;
`else
  assign tx_o = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (capture) state_d = StSend;
`ifdef FPGA_EXIT_REPORTER_UART_EN
      StSend: if (uart_done && (idx_q == 5'(MSG_LEN - 1))) state_d = StDone;
`else
      StSend: state_d = StDone;
`endif
      StDone: if (capture) state_d = StSend;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy_o = (state_q == StSend);
    done_o = (state_q == StDone);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      value_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      valid_q <= exit_valid_i;
      if (capture) begin
        value_q <= exit_value_i;
        pass_q  <= (exit_value_i == 32'd0);
        fail_q  <= (exit_value_i != 32'd0);
      end
    end
  end

  assign value_o    = value_q;
  assign pass_led_o = pass_q;
  assign fail_led_o = fail_q;

endmodule

// File: tb/tb_fpga_exit_reporter.sv
module tb_fpga_exit_reporter;

  localparam int unsigned Clks   = 4;
  localparam int unsigned MsgLen = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        exit_valid;
  logic [31:0] exit_value;
  logic        tx, busy, done, pass_led, fail_led;
  logic [31:0] value;

  int          n_checks = 0;
  int          n_err    = 0;
  int unsigned cyc      = 0;
  int unsigned tx_low_cnt = 0;

  // Reference model: what the LEDs and value output should show.
  logic [31:0] m_value;
  logic        m_pass, m_fail;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx !== 1'b1) tx_low_cnt <= tx_low_cnt + 1;

  fpga_exit_reporter #(
    .CLKS_PER_BIT(Clks)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .exit_valid_i(exit_valid),
    .exit_value_i(exit_value),
    .tx_o        (tx),
    .busy_o      (busy),
    .done_o      (done),
    .pass_led_o  (pass_led),
    .fail_led_o  (fail_led),
    .value_o     (value)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_value"}, 64'(value), 64'(m_value));
    check_eq({tag, "_pass"}, 64'(pass_led), 64'(m_pass));
    check_eq({tag, "_fail"}, 64'(fail_led), 64'(m_fail));
  endtask

  task automatic model_reset();
    m_value = '0;
    m_pass  = 1'b0;
    m_fail  = 1'b0;
  endtask

`ifdef FPGA_EXIT_REPORTER_UART_EN
  logic [7:0]  rx_q[$];
  int unsigned start_q[$];
  logic        done_prev = 1'b0;
  int unsigned done_rise_cyc = 0;

  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc <= cyc;
    done_prev <= done;
  end

  // UART receiver: finds a start bit, samples each bit mid-way.
  initial begin : rx_mon
    logic [7:0]  b;
    bit          aborted;
    int unsigned t0;
    int unsigned w;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        t0 = cyc;
        aborted = 1'b0;
        b = '0;
        for (int i = 0; i < 9; i++) begin
          w = (i == 0) ? (Clks + Clks / 2) : Clks;
          repeat (w) begin
            @(negedge clk);
            if (rst !== 1'b0) aborted = 1'b1;
          end
          if (i < 8) b[i] = tx;
          else if (tx !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) begin
          rx_q.push_back(b);
          start_q.push_back(t0);
        end
      end
    end
  end

  task automatic expect_msg(input logic [31:0] v);
    logic [7:0] e[$];
    string      prefix;
    string      hexd;
    int         n;
    prefix = "EXIT 0x";
    hexd   = "0123456789ABCDEF";
    for (int i = 0; i < 7; i++) e.push_back(prefix.getc(i));
    for (int k = 0; k < 8; k++) e.push_back(hexd.getc(int'((v >> (28 - 4 * k)) & 32'hF)));
    e.push_back(8'h0D);
    e.push_back(8'h0A);
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq("done_wait", 64'(done), 64'(1));
    check_eq("busy_after", 64'(busy), 64'(0));
    check_eq("rx_len", 64'(rx_q.size()), 64'(MsgLen));
    for (int i = 0; i < MsgLen; i++) begin
      if (i < rx_q.size()) check_eq($sformatf("rx_byte%0d", i), 64'(rx_q[i]), 64'(e[i]));
    end
    if (start_q.size() > 0)
      check_eq("msg_cycles", 64'(done_rise_cyc - start_q[0]), 64'(170 * Clks));
    check_model("msg_end");
  endtask
`endif

  // Drive a rising edge with value v, holding valid for hold cycles.
  task automatic capture(input logic [31:0] v, input int hold);
    @(negedge clk);
`ifdef FPGA_EXIT_REPORTER_UART_EN
    rx_q.delete();
    start_q.delete();
`endif
    exit_value = v;
    exit_valid = 1'b1;
    @(negedge clk);
    m_value = v;
    m_pass  = (v == 32'd0);
    m_fail  = (v != 32'd0);
    check_model("cap");
    check_eq("cap_busy", 64'(busy), 64'(1));
    check_eq("cap_done", 64'(done), 64'(0));
    for (int i = 1; i < hold; i++) begin
      exit_value = $urandom;
      @(negedge clk);
      check_eq("hold_value", 64'(value), 64'(m_value));
    end
    exit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exit_valid = 1'b0;
    exit_value = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Asynchronous reset from the middle of a clock phase; check without a clock.
  task automatic async_reset_check();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst_tx", 64'(tx), 64'(1));
    check_eq("arst_busy", 64'(busy), 64'(0));
    check_eq("arst_done", 64'(done), 64'(0));
    check_model("arst");
    @(negedge clk);
    rst = 1'b0;
    exit_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int unsigned low0;
    logic [31:0] v;
    int          n;
    do_reset();

    low0 = tx_low_cnt;
    repeat (100) @(negedge clk);
    check_eq("idle_tx_low", 64'(tx_low_cnt - low0), 64'(0));
    check_eq("idle_busy", 64'(busy), 64'(0));
    check_eq("idle_done", 64'(done), 64'(0));
    check_model("idle");

`ifdef FPGA_EXIT_REPORTER_UART_EN
    capture(32'h0000_0000, 1);
    expect_msg(32'h0000_0000);

    // Held high far past the message: exactly one report.
    capture(32'hDEAD_BEEF, 2000);
    expect_msg(32'hDEAD_BEEF);

    // A second edge while sending is dropped.
    capture(32'hDEAD_BEEF, 2);
    repeat (200) @(negedge clk);
    exit_value = 32'h1;
    exit_valid = 1'b1;
    @(negedge clk);
    exit_valid = 1'b0;
    check_model("ignored");
    check_eq("ignored_busy", 64'(busy), 64'(1));
    expect_msg(32'hDEAD_BEEF);

    capture(32'h0000_0001, 1);
    expect_msg(32'h0000_0001);

    // Reset in the middle of the message, then a fresh report.
    capture($urandom, 1);
    n = 0;
    while (rx_q.size() < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx5_wait", 64'(rx_q.size() >= 5), 64'(1));
    repeat (2 * Clks) @(negedge clk);
    async_reset_check();
    repeat (30) @(negedge clk);
    v = $urandom;
    capture(v, 1);
    expect_msg(v);

    for (int t = 0; t < 4; t++) begin
      v = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      capture(v, $urandom_range(1, 8));
      repeat ($urandom_range(20, 500)) @(negedge clk);
      exit_value = $urandom;
      exit_valid = 1'b1;
      @(negedge clk);
      exit_valid = 1'b0;
      check_model("glitch");
      expect_msg(v);
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end
`else
    low0 = tx_low_cnt;
    for (int t = 0; t < 20; t++) begin
      v = (t == 0) ? 32'h5 : (($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      capture(v, 1);
      @(negedge clk);
      check_eq("nouart_busy", 64'(busy), 64'(0));
      check_eq("nouart_done", 64'(done), 64'(1));
      // Valid held high across SEND and DONE must not re-capture.
      capture($urandom, $urandom_range(2, 5));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check_eq("nouart_done2", 64'(done), 64'(1));
      check_model("nouart");
    end
    capture(32'hCAFE_0001, 1);
    async_reset_check();
    repeat (5) @(negedge clk);
    check_eq("nouart_tx_low", 64'(tx_low_cnt - low0), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
